// File: rtl/data_memory.sv
// Byte-addressable DEPTH x 32 data memory for the single-cycle RV32I core; DATA_MEM_MISALIGN_TRAP_EN adds a misaligned-store trap/log.
// Latency: loads 0 cycles (combinational), stores commit on the rising edge of clk.
// Backpressure: none; one access per cycle is always accepted.
module data_memory #(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] Address,
    input  logic [31:0] DataWr,
    input  logic        DMWr,
    input  logic [2:0]  DMCtrl,
    input  logic        ErrClr,
    output logic [31:0] DataRd,
    output logic        MisalignErr,
    output logic [31:0] ErrAddr
);

    localparam int AW = $clog2(DEPTH);

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] word_idx;
    logic [1:0]    lane;
    logic          is_byte;
    logic          is_half;
    logic          is_word;
    logic          load_ok;
    logic          store_ok;
    logic          misalign;
    logic          store_en;
    logic [3:0]    lane_en;
    logic [31:0]   wr_data;
    logic [31:0]   rd_word;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;

    assign word_idx = Address[AW+1:2];
    assign lane     = Address[1:0];

    // funct3[1:0] gives the size; funct3[2] is the unsigned flag, legal only on byte/half loads
    assign is_byte  = (DMCtrl[1:0] == 2'b00);
    assign is_half  = (DMCtrl[1:0] == 2'b01);
    assign is_word  = (DMCtrl == 3'b010);
    assign load_ok  = is_byte | is_half | is_word;
    assign store_ok = load_ok & ~DMCtrl[2];

`ifdef DATA_MEM_MISALIGN_TRAP_EN
    assign misalign = (is_half & Address[0]) | (is_word & (|Address[1:0]));
`else
    assign misalign = 1'b0;
`endif

    assign store_en = DMWr & store_ok & ~misalign;

    always_comb begin
        lane_en = 4'b0000;
        if (is_word) begin
            lane_en = 4'b1111;
        end else if (is_half) begin
            lane_en = Address[1] ? 4'b1100 : 4'b0011;
        end else if (is_byte) begin
            lane_en = 4'b0001 << lane;
        end
    end

    // Replicating the store data lets every lane pick its byte from the same position
    always_comb begin
        if (is_byte) begin
            wr_data = {4{DataWr[7:0]}};
        end else if (is_half) begin
            wr_data = {2{DataWr[15:0]}};
        end else begin
            wr_data = DataWr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (store_en) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_en[b]) begin
                    mem[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    assign rd_word = mem[word_idx];
    assign rd_byte = rd_word[8*lane +: 8];
    assign rd_half = Address[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        DataRd = '0;
        if (load_ok && !misalign) begin
            if (is_byte) begin
                DataRd = {{24{~DMCtrl[2] & rd_byte[7]}}, rd_byte};
            end else if (is_half) begin
                DataRd = {{16{~DMCtrl[2] & rd_half[15]}}, rd_half};
            end else begin
                DataRd = rd_word;
            end
        end
    end

`ifdef DATA_MEM_MISALIGN_TRAP_EN
    logic        fault;
    logic        err_q;
    logic [31:0] err_addr_q;

    assign fault = DMWr & store_ok & misalign;

    // A fault coinciding with ErrClr restarts the log with the new address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else if (fault) begin
            err_q <= 1'b1;
            if (!err_q || ErrClr) begin
                err_addr_q <= Address;
            end
        end else if (ErrClr) begin
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end
    end

    assign MisalignErr = err_q;
    assign ErrAddr     = err_addr_q;
`else
    logic unused_ok;

    assign unused_ok   = ^{ErrClr, Address[31:AW+2]};
    assign MisalignErr = 1'b0;
    assign ErrAddr     = '0;
`endif

endmodule

// File: tb/tb_data_memory.sv
// Self-checking bench for data_memory: vector table with an expected-value queue, plus reset and trap sequences.
module tb_data_memory;

    logic        clk;
    logic        rst;
    logic [31:0] Address;
    logic [31:0] DataWr;
    logic        DMWr;
    logic [2:0]  DMCtrl;
    logic        ErrClr;
    logic [31:0] DataRd;
    logic        MisalignErr;
    logic [31:0] ErrAddr;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        we;
        logic [2:0]  ctrl;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t        vecs [18];
    logic [31:0] exp_q [$];

    data_memory #(.DEPTH(256)) dut (
        .clk         (clk),
        .rst         (rst),
        .Address     (Address),
        .DataWr      (DataWr),
        .DMWr        (DMWr),
        .DMCtrl      (DMCtrl),
        .ErrClr      (ErrClr),
        .DataRd      (DataRd),
        .MisalignErr (MisalignErr),
        .ErrAddr     (ErrAddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (checks=%0d errors=%0d)", checks, errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Applies inputs just after a rising edge and lets the combinational read settle
    task automatic drive(input logic we, input logic [2:0] ctrl, input logic [31:0] addr,
                         input logic [31:0] wd, input logic clr);
        DMWr    = we;
        DMCtrl  = ctrl;
        Address = addr;
        DataWr  = wd;
        ErrClr  = clr;
        #2;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic we, input logic [2:0] ctrl, input logic [31:0] addr,
                                input logic [31:0] wd, input logic [31:0] exp);
        vec_t v;
        v.we     = we;
        v.ctrl   = ctrl;
        v.addr   = addr;
        v.wdata  = wd;
        v.exp_rd = exp;
        return v;
    endfunction

    initial begin
        // Expected DataRd is the value seen during the cycle, i.e. before any store in that cycle commits
        vecs[0]  = mk(1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h00000000);
        vecs[1]  = mk(0, 3'b000, 32'h13,  32'h0,        32'hFFFFFFDE);
        vecs[2]  = mk(0, 3'b100, 32'h13,  32'h0,        32'h000000DE);
        vecs[3]  = mk(0, 3'b001, 32'h12,  32'h0,        32'hFFFFDEAD);
        vecs[4]  = mk(0, 3'b101, 32'h10,  32'h0,        32'h0000BEEF);
        vecs[5]  = mk(0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF);
        vecs[6]  = mk(1, 3'b000, 32'h11,  32'h0000005A, 32'hFFFFFFBE);
        vecs[7]  = mk(1, 3'b001, 32'h12,  32'h00001234, 32'hFFFFDEAD);
        vecs[8]  = mk(0, 3'b010, 32'h10,  32'h0,        32'h12345AEF);
        vecs[9]  = mk(1, 3'b010, 32'h400, 32'hCAFEF00D, 32'h00000000);
        vecs[10] = mk(0, 3'b010, 32'h000, 32'h0,        32'hCAFEF00D);
        vecs[11] = mk(1, 3'b011, 32'h000, 32'h12345678, 32'h00000000);
        vecs[12] = mk(0, 3'b010, 32'h000, 32'h0,        32'hCAFEF00D);
        vecs[13] = mk(0, 3'b110, 32'h000, 32'h0,        32'h00000000);
        vecs[14] = mk(1, 3'b100, 32'h10,  32'hFFFFFFFF, 32'h000000EF);
        vecs[15] = mk(1, 3'b101, 32'h10,  32'hFFFFFFFF, 32'h00005AEF);
        vecs[16] = mk(1, 3'b111, 32'h10,  32'hFFFFFFFF, 32'h00000000);
        vecs[17] = mk(0, 3'b010, 32'h10,  32'h0,        32'h12345AEF);

        rst = 1'b1;
        drive(0, 3'b010, 32'h10, 32'h0, 0);
        check("reset_rd", DataRd, 32'h0);
        check("reset_err", {31'b0, MisalignErr}, 32'h0);
        check("reset_erraddr", ErrAddr, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            drive(vecs[i].we, vecs[i].ctrl, vecs[i].addr, vecs[i].wdata, 0);
            exp_q.push_back(vecs[i].exp_rd);
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL vec%0d: expected-value queue empty", i);
            end else begin
                check($sformatf("vec%0d", i), DataRd, exp_q.pop_front());
            end
            step();
        end

`ifdef DATA_MEM_MISALIGN_TRAP_EN
        drive(1, 3'b001, 32'h21, 32'h0000BEEF, 0);
        step();
        drive(0, 3'b010, 32'h20, 32'h0, 0);
        check("trap_sh_suppressed", DataRd, 32'h0);
        check("trap_sh_flag", {31'b0, MisalignErr}, 32'h1);
        check("trap_sh_addr", ErrAddr, 32'h21);

        drive(1, 3'b010, 32'h32, 32'hFFFFFFFF, 0);
        step();
        drive(0, 3'b010, 32'h30, 32'h0, 0);
        check("trap_sw_suppressed", DataRd, 32'h0);
        check("trap_sw_flag", {31'b0, MisalignErr}, 32'h1);
        check("trap_sw_addr_held", ErrAddr, 32'h21);

        drive(1, 3'b010, 32'h20, 32'hAABBCCDD, 0);
        step();
        drive(0, 3'b010, 32'h21, 32'h0, 0);
        check("trap_lw_misaligned", DataRd, 32'h0);
        drive(0, 3'b101, 32'h21, 32'h0, 0);
        check("trap_lhu_misaligned", DataRd, 32'h0);
        drive(0, 3'b100, 32'h21, 32'h0, 0);
        check("trap_lbu_odd", DataRd, 32'h000000CC);
        drive(0, 3'b001, 32'h22, 32'h0, 0);
        check("trap_lh_aligned", DataRd, 32'hFFFFAABB);

        drive(1, 3'b010, 32'h36, 32'h1, 1);
        step();
        drive(0, 3'b010, 32'h34, 32'h0, 1);
        check("clr_fault_flag", {31'b0, MisalignErr}, 32'h1);
        check("clr_fault_addr", ErrAddr, 32'h36);
        check("clr_fault_suppressed", DataRd, 32'h0);
        step();
        drive(0, 3'b010, 32'h34, 32'h0, 0);
        check("clr_flag", {31'b0, MisalignErr}, 32'h0);
        check("clr_addr", ErrAddr, 32'h0);
        step();
        check("hold_flag", {31'b0, MisalignErr}, 32'h0);
`else
        drive(1, 3'b001, 32'h21, 32'h0000BEEF, 1);
        step();
        drive(0, 3'b101, 32'h20, 32'h0, 0);
        check("notrap_lhu", DataRd, 32'h0000BEEF);
        check("notrap_flag", {31'b0, MisalignErr}, 32'h0);
        check("notrap_addr", ErrAddr, 32'h0);
        drive(0, 3'b010, 32'h23, 32'h0, 0);
        check("notrap_lw_trunc", DataRd, 32'h0000BEEF);
        drive(0, 3'b001, 32'h21, 32'h0, 0);
        check("notrap_lh_trunc", DataRd, 32'hFFFFBEEF);
`endif

        drive(1, 3'b010, 32'h20, 32'h11111111, 0);
        step();
        drive(0, 3'b010, 32'h20, 32'h0, 0);
        check("pre_reset_word", DataRd, 32'h11111111);
        drive(1, 3'b010, 32'h20, 32'h22222222, 0);
        rst = 1'b1;
        #1;
        check("async_reset_rd", DataRd, 32'h0);
        check("async_reset_flag", {31'b0, MisalignErr}, 32'h0);
        check("async_reset_addr", ErrAddr, 32'h0);
        step();
        check("reset_edge_no_write", DataRd, 32'h0);
        DMWr = 1'b0;
        rst  = 1'b0;
        step();
        drive(0, 3'b010, 32'h20, 32'h0, 0);
        check("post_reset_0x20", DataRd, 32'h0);
        drive(0, 3'b010, 32'h10, 32'h0, 0);
        check("post_reset_0x10", DataRd, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
